// File: rtl/servo_gate_pkg.sv
// Shared types for the servo gate guard: per-phase FSM state,
// dead-time target and register map.
package servo_gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DT   = 2'd1,
    ST_U_ON = 2'd2,
    ST_L_ON = 2'd3
  } phase_state_e;

  typedef enum logic {
    TGT_U = 1'b0,
    TGT_L = 1'b1
  } target_e;

  localparam logic [1:0] ADDR_DT   = 2'd0;
  localparam logic [1:0] ADDR_EN   = 2'd1;
  localparam logic [1:0] ADDR_FCLR = 2'd2;

endpackage

// File: rtl/servo_deadtime_phase.sv
// One phase of dead-time insertion: OFF/DT/U_ON/L_ON FSM + counter.
// Ports: clk_i, rst_i (async high), en_i (hold OFF when low),
//   u_req_i/l_req_i raw requests, dt_i reload value,
//   u_on_o/l_on_o registered on-state decode.
import servo_gate_pkg::*;

module servo_deadtime_phase #(
  parameter int DTW = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           u_req_i,
  input  logic           l_req_i,
  input  logic [DTW-1:0] dt_i,
  output logic           u_on_o,
  output logic           l_on_o
);

  phase_state_e   state_q, state_d;
  target_e        tgt_q, tgt_d;
  logic [DTW-1:0] cnt_q, cnt_d;

  logic    req_u;
  logic    req_l;
  logic    req_any;
  target_e req_tgt;

  // Both set or both clear is a NONE request.
  assign req_u   = u_req_i & ~l_req_i;
  assign req_l   = l_req_i & ~u_req_i;
  assign req_any = req_u | req_l;
  assign req_tgt = req_l ? TGT_L : TGT_U;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (req_any) begin
            state_d = ST_DT;
            tgt_d   = req_tgt;
            cnt_d   = dt_i;
          end
        end
        ST_DT: begin
          if (!req_any) begin
            state_d = ST_OFF;
          end else if (req_tgt != tgt_q) begin
            tgt_d = req_tgt;
            cnt_d = dt_i;
          end else if (cnt_q == '0) begin
            state_d = (tgt_q == TGT_L) ? ST_L_ON
                                       : ST_U_ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_U_ON: begin
          if (!req_any) begin
            state_d = ST_OFF;
          end else if (req_l) begin
            state_d = ST_DT;
            tgt_d   = TGT_L;
            cnt_d   = dt_i;
          end
        end
        ST_L_ON: begin
          if (!req_any) begin
            state_d = ST_OFF;
          end else if (req_u) begin
            state_d = ST_DT;
            tgt_d   = TGT_U;
            cnt_d   = dt_i;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      tgt_q   <= TGT_U;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign u_on_o = (state_q == ST_U_ON);
  assign l_on_o = (state_q == ST_L_ON);

endmodule

// File: rtl/servo_gate_guard.sv
// Gate-driver guard: dead time per phase, U/L interlock, latched
// active-low driver fault with irq, MMS write-only register file.
// Ports: clk, reset (async high), MMS_addr/write/writedata,
//   Udrive_in/Ldrive_in raw requests, fault_n pin,
//   Uout/Lout guarded gates, faultirq one-cycle pulse.
// Option: SERVO_GATE_FAULT_FILTER_EN adds a FLT_FILT-sample filter.
import servo_gate_pkg::*;

module servo_gate_guard #(
  parameter int             DTW      = 8,
  parameter logic [DTW-1:0] DT_RESET = DTW'(20),
  parameter int             FLT_FILT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MMS_addr,
  input  logic        MMS_write,
  input  logic [31:0] MMS_writedata,
  input  logic [2:0]  Udrive_in,
  input  logic [2:0]  Ldrive_in,
  input  logic        fault_n,
  output logic [2:0]  Uout,
  output logic [2:0]  Lout,
  output logic        faultirq
);

  logic [DTW-1:0] dt_q, dt_d;
  logic           en_q, en_d;
  logic           sync1_q, sync2_q;
  logic           lat_q, lat_d;
  logic           irq_q, irq_d;

  logic wr_dt;
  logic wr_en;
  logic wr_clr;
  logic flt_s;
  logic flt_hit;
  logic ph_en;

  logic [2:0] u_on;
  logic [2:0] l_on;

  assign wr_dt  = MMS_write && (MMS_addr == ADDR_DT);
  assign wr_en  = MMS_write && (MMS_addr == ADDR_EN);
  assign wr_clr = MMS_write && (MMS_addr == ADDR_FCLR)
                  && MMS_writedata[0];

  assign dt_d = wr_dt ? MMS_writedata[DTW-1:0] : dt_q;
  assign en_d = wr_en ? MMS_writedata[0] : en_q;

  // Synchronised fault, active high.
  assign flt_s = sync2_q;

`ifdef SERVO_GATE_FAULT_FILTER_EN
  localparam int FCW = $clog2(FLT_FILT + 1);
  localparam logic [FCW-1:0] FMAX = FCW'(FLT_FILT - 1);

  logic [FCW-1:0] fcnt_q, fcnt_d;

  // Counts prior consecutive low samples; the sample that
  // finds FLT_FILT-1 behind it is the accepting one.
  assign flt_hit = flt_s && (fcnt_q >= FMAX);

  always_comb begin
    fcnt_d = fcnt_q;
    if (!flt_s) begin
      fcnt_d = '0;
    end else if (fcnt_q < FMAX) begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end
`else
  assign flt_hit = flt_s;
`endif

  // Fault beats a same-cycle clear; clear needs the pin idle.
  always_comb begin
    lat_d = lat_q;
    if (flt_hit) begin
      lat_d = 1'b1;
    end else if (wr_clr && !flt_s) begin
      lat_d = 1'b0;
    end
  end

  assign irq_d = flt_hit & ~lat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dt_q    <= DT_RESET;
      en_q    <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lat_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      dt_q    <= dt_d;
      en_q    <= en_d;
      sync1_q <= ~fault_n;
      sync2_q <= sync1_q;
      lat_q   <= lat_d;
      irq_q   <= irq_d;
    end
  end

  assign ph_en = en_q & ~lat_q;

  for (genvar p = 0; p < 3; p++) begin : g_ph
    servo_deadtime_phase #(
      .DTW (DTW)
    ) u_ph (
      .clk_i   (clk),
      .rst_i   (reset),
      .en_i    (ph_en),
      .u_req_i (Udrive_in[p]),
      .l_req_i (Ldrive_in[p]),
      .dt_i    (dt_q),
      .u_on_o  (u_on[p]),
      .l_on_o  (l_on[p])
    );
  end

  // Gate the registered on-states so a fault drops the
  // gates on the same edge the latch sets.
  assign Uout     = u_on & {3{ph_en}};
  assign Lout     = l_on & {3{ph_en}};
  assign faultirq = irq_q;

endmodule

// File: tb/tb_servo_gate_guard.sv
// Scoreboard bench for servo_gate_guard: directed vectors push
// expected gate/irq values, a monitor pops and compares.
import servo_gate_pkg::*;

module tb_servo_gate_guard;

`ifdef SERVO_GATE_FAULT_FILTER_EN
  localparam int PW = 4;
  localparam int FL = 6;
`else
  localparam int PW = 1;
  localparam int FL = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  MMS_addr;
  logic        MMS_write;
  logic [31:0] MMS_writedata;
  logic [2:0]  Udrive_in;
  logic [2:0]  Ldrive_in;
  logic        fault_n;
  logic [2:0]  Uout;
  logic [2:0]  Lout;
  logic        faultirq;

  typedef struct {
    logic [2:0] u;
    logic [2:0] l;
    logic       irq;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  servo_gate_guard dut (
    .clk           (clk),
    .reset         (reset),
    .MMS_addr      (MMS_addr),
    .MMS_write     (MMS_write),
    .MMS_writedata (MMS_writedata),
    .Udrive_in     (Udrive_in),
    .Ldrive_in     (Ldrive_in),
    .fault_n       (fault_n),
    .Uout          (Uout),
    .Lout          (Lout),
    .faultirq      (faultirq)
  );

  // Monitor: one entry per clock edge, plus one on an
  // asynchronous reset rise.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (Uout !== e.u || Lout !== e.l ||
            faultirq !== e.irq) begin
          errors++;
          $display("FAIL %s: got U=%b L=%b irq=%b, need U=%b L=%b irq=%b",
                   e.nm, Uout, Lout, faultirq, e.u, e.l, e.irq);
        end
        checks++;
        if ((Uout & Lout) !== 3'b000) begin
          errors++;
          $display("FAIL %s_overlap: got U&L=%b, need 000",
                   e.nm, Uout & Lout);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, need finish");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [2:0] eu, input logic [2:0] el,
                      input logic ei, input string nm);
    exp_t e;
    e.u   = eu;
    e.l   = el;
    e.irq = ei;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input logic [2:0] eu, input logic [2:0] el,
                      input logic ei, input string nm);
    push(eu, el, ei, nm);
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input logic [2:0] eu,
                       input logic [2:0] el, input string nm);
    repeat (n) tick(eu, el, 1'b0, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input logic [2:0] eu, input logic [2:0] el,
                    input string nm);
    MMS_addr      = a;
    MMS_writedata = d;
    MMS_write     = 1'b1;
    tick(eu, el, 1'b0, nm);
    MMS_write     = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    MMS_addr      = 2'd0;
    MMS_write     = 1'b0;
    MMS_writedata = 32'd0;
    Udrive_in     = 3'b000;
    Ldrive_in     = 3'b000;
    fault_n       = 1'b1;
    @(negedge clk);
    ticks(3, 3'b000, 3'b000, "reset");
    reset = 1'b0;

    // enable defaults to 0: request is held off
    Udrive_in = 3'b001;
    ticks(10, 3'b000, 3'b000, "en0_hold");
    Udrive_in = 3'b000;
    tick(3'b000, 3'b000, 1'b0, "idle");
    wr(ADDR_DT, 32'd5, 3'b000, 3'b000, "wr_dt5");
    wr(ADDR_EN, 32'd1, 3'b000, 3'b000, "wr_en");

    // U on after deadtime+2 edges
    Udrive_in = 3'b001;
    ticks(6, 3'b000, 3'b000, "u_dt");
    tick(3'b001, 3'b000, 1'b0, "u_on");
    ticks(2, 3'b001, 3'b000, "u_hold");

    // swap to L: U drops on 1st edge, L after 7
    Udrive_in = 3'b000;
    Ldrive_in = 3'b001;
    ticks(6, 3'b000, 3'b000, "swap_dt");
    tick(3'b000, 3'b001, 1'b0, "swap_l_on");

    // both requested on phase1 is NONE
    Udrive_in = 3'b010;
    Ldrive_in = 3'b011;
    ticks(20, 3'b000, 3'b001, "both_none");
    Ldrive_in = 3'b001;
    ticks(6, 3'b000, 3'b001, "rel_dt");
    tick(3'b010, 3'b001, 1'b0, "rel_u_on");
    Udrive_in = 3'b000;
    Ldrive_in = 3'b000;
    tick(3'b000, 3'b000, 1'b0, "all_off");

    // retarget during DT with deadtime 10
    wr(ADDR_DT, 32'd10, 3'b000, 3'b000, "wr_dt10");
    Udrive_in = 3'b001;
    ticks(4, 3'b000, 3'b000, "rt_u");
    Udrive_in = 3'b000;
    Ldrive_in = 3'b001;
    ticks(11, 3'b000, 3'b000, "rt_dt");
    tick(3'b000, 3'b001, 1'b0, "rt_l_on");

    // deadtime write while L is on; then phase2 U
    wr(ADDR_DT, 32'd2, 3'b000, 3'b001, "wr_dt2");
    Udrive_in = 3'b100;
    ticks(3, 3'b000, 3'b001, "p2_dt");
    tick(3'b100, 3'b001, 1'b0, "p2_on");

`ifdef SERVO_GATE_FAULT_FILTER_EN
    // short pulse is filtered out
    fault_n = 1'b0;
    ticks(3, 3'b100, 3'b001, "flt3");
    fault_n = 1'b1;
    ticks(6, 3'b100, 3'b001, "flt3_ign");
`endif

    // fault pulse: outputs off FL edges after fall
    fault_n = 1'b0;
    for (int i = 1; i <= FL + 1; i++) begin
      if (i > PW) fault_n = 1'b1;
      if (i < FL)
        tick(3'b100, 3'b001, 1'b0, "flt_pre");
      else if (i == FL)
        tick(3'b000, 3'b000, 1'b1, "flt_irq");
      else
        tick(3'b000, 3'b000, 1'b0, "flt_off");
    end

    // clear while pin low keeps the latch, no new irq
    fault_n = 1'b0;
    ticks(3, 3'b000, 3'b000, "flt_low");
    wr(ADDR_FCLR, 32'd1, 3'b000, 3'b000, "clr_low");
    ticks(2, 3'b000, 3'b000, "clr_low_hold");

    // clear after release resumes through DT
    fault_n = 1'b1;
    ticks(2, 3'b000, 3'b000, "rel");
    wr(ADDR_FCLR, 32'd1, 3'b000, 3'b000, "clr");
    ticks(3, 3'b000, 3'b000, "resume_dt");
    tick(3'b100, 3'b001, 1'b0, "resume_on");

    // async reset mid-operation
    push(3'b000, 3'b000, 1'b0, "async_rst");
    #2;
    reset = 1'b1;
    #2;
    ticks(2, 3'b000, 3'b000, "rst_hold");
    reset = 1'b0;
    ticks(2, 3'b000, 3'b000, "post_rst");

    // deadtime back to its reset value of 20
    wr(ADDR_EN, 32'd1, 3'b000, 3'b000, "wr_en2");
    ticks(21, 3'b000, 3'b000, "dt20");
    tick(3'b100, 3'b001, 1'b0, "dt20_on");

    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
